// File: rtl/next_pc_predictor_pkg.sv
// Shared types for the next-PC predictor: resolve-kind encodings, BTB entry
// layout and saturating-counter helpers.
package next_pc_predictor_pkg;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JMP    = 2'b10,
    NPC_REG    = 2'b11
  } npc_kind_e;

  localparam logic [1:0] CNT_WEAK_T = 2'd2;
  localparam logic [1:0] CNT_MAX    = 2'd3;

  // Entry fields are sized for the widest supported datapath; narrower
  // instances use the low bits only.
  localparam int BTB_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [BTB_MAX_W-1:0] tag;
    logic [BTB_MAX_W-1:0] target;
    logic [1:0]           cnt;
  } btb_entry_t;

  function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic up);
    if (up) return (c == CNT_MAX) ? CNT_MAX : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

endpackage

// File: rtl/next_pc_predictor_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// single-port update from the resolving instruction, written at the edge.
module btb_table
  import next_pc_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-3:0] rd_wpc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            upd_en,
  input  logic            upd_taken,
  input  logic [XLEN-3:0] upd_wpc,
  input  logic [XLEN-1:0] upd_target
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - 2 - IDXW;

  btb_entry_t      mem_q [ENTRIES];
  btb_entry_t      mem_d [ENTRIES];
  logic [IDXW-1:0] rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            rd_hit, wr_hit;

  assign rd_idx = rd_wpc[IDXW-1:0];
  assign rd_tag = rd_wpc[XLEN-3:IDXW];
  assign wr_idx = upd_wpc[IDXW-1:0];
  assign wr_tag = upd_wpc[XLEN-3:IDXW];

  // Lookup reads mem_q, so a same-cycle update to the same slot is not visible.
  always_comb begin
    rd_hit    = mem_q[rd_idx].valid && (mem_q[rd_idx].tag[TAGW-1:0] == rd_tag);
    rd_taken  = rd_hit && (mem_q[rd_idx].cnt >= CNT_WEAK_T);
    rd_target = mem_q[rd_idx].target[XLEN-1:0];
  end

  always_comb begin
    mem_d  = mem_q;
    wr_hit = mem_q[wr_idx].valid && (mem_q[wr_idx].tag[TAGW-1:0] == wr_tag);
    if (upd_en) begin
      if (upd_taken) begin
        if (wr_hit) begin
          mem_d[wr_idx].cnt = cnt_step(mem_q[wr_idx].cnt, 1'b1);
        end else begin
          mem_d[wr_idx].valid = 1'b1;
          mem_d[wr_idx].tag   = BTB_MAX_W'(wr_tag);
          mem_d[wr_idx].cnt   = CNT_WEAK_T;
        end
        mem_d[wr_idx].target = BTB_MAX_W'(upd_target);
      end else if (wr_hit) begin
        mem_d[wr_idx].cnt = cnt_step(mem_q[wr_idx].cnt, 1'b0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i].valid <= 1'b0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch PC register with BTB-driven prediction and redirect on mispredict
// detected at the resolve stage.
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ENTRIES  = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [15:0]     ex_imm,
  input  logic [25:0]     ex_jaddr,
  input  logic [XLEN-1:0] ex_reg,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush
);
  npc_kind_e       kind;
  logic [XLEN-1:0] ex_pc4, br_off, actual_npc, pred_npc;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc, btb_target;
  logic            mispredict, btb_taken;

  assign kind   = npc_kind_e'(ex_kind);
  assign ex_pc4 = ex_pc + XLEN'(4);
  assign br_off = {{(XLEN-18){ex_imm[15]}}, ex_imm, 2'b00};

  always_comb begin
    actual_npc = ex_pc4;
    case (kind)
      NPC_BRANCH: actual_npc = ex_taken ? ex_pc4 + br_off : ex_pc4;
      NPC_JMP:    actual_npc = {ex_pc4[XLEN-1:28], ex_jaddr, 2'b00};
      NPC_REG:    actual_npc = ex_reg;
      default:    actual_npc = ex_pc4;
    endcase
  end

  assign pred_npc   = ex_pred_taken ? ex_pred_target : ex_pc4;
  assign mispredict = ex_valid && (actual_npc != pred_npc);
  assign flush      = mispredict;

  btb_table #(.XLEN(XLEN), .ENTRIES(ENTRIES)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_wpc     (pc_q[XLEN-1:2]),
    .rd_taken   (btb_taken),
    .rd_target  (btb_target),
    .upd_en     (ex_valid && (kind != NPC_PC4)),
    .upd_taken  ((kind != NPC_BRANCH) || ex_taken),
    .upd_wpc    (ex_pc[XLEN-1:2]),
    .upd_target (actual_npc)
  );

  assign pc_inc      = pc_q + XLEN'(4);
  assign pc          = pc_q;
  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : pc_inc;

  // Redirect beats stall; otherwise follow the fetch-side prediction.
  always_comb begin
    pc_d = pred_target;
    if (mispredict)  pc_d = actual_npc;
    else if (stall)  pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Bench for next_pc_predictor: directed vectors, an abstract BTB/PC model
// checked every cycle, and literal expectations at key points.
module tb_next_pc_predictor;
  localparam int          ENTRIES  = 8;
  localparam int          IDXW     = 3;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, ex_taken, ex_pred_taken;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc, ex_reg, ex_pred_target;
  logic [15:0] ex_imm;
  logic [25:0] ex_jaddr;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  next_pc_predictor #(.XLEN(32), .ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .ex_kind(ex_kind),
    .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_jaddr(ex_jaddr),
    .ex_reg(ex_reg), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: BTB as per-slot arrays, PC as a plain number.
  logic        m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];
  logic [31:0] m_pc;
  bit          started = 0;

  function automatic logic [31:0] m_actual();
    logic [31:0] pc4;
    pc4 = ex_pc + 32'd4;
    case (ex_kind)
      2'b01:   return ex_taken ? pc4 + 32'(int'($signed(ex_imm)) * 4) : pc4;
      2'b10:   return (pc4 & 32'hF000_0000) | (32'(ex_jaddr) << 2);
      2'b11:   return ex_reg;
      default: return pc4;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    int          i, j;
    bit          hit, ptk, mp, ehit, tk;
    logic [31:0] a, p, ptgt;
    i    = int'((m_pc >> 2) % ENTRIES);
    hit  = m_v[i] === 1'b1 && m_tag[i] == (m_pc >> (IDXW + 2));
    ptk  = hit && m_cnt[i] >= 2;
    ptgt = ptk ? m_tgt[i] : m_pc + 32'd4;
    a    = m_actual();
    p    = ex_pred_taken ? ex_pred_target : ex_pc + 32'd4;
    mp   = ex_valid && (a != p);
    if (started) begin
      chk("model_pc", pc, m_pc);
      chk("model_pred_taken", 32'(pred_taken), 32'(ptk));
      chk("model_pred_target", pred_target, ptgt);
      chk("model_flush", 32'(flush), 32'(mp));
    end
    if (!rst_n) begin
      m_pc = RESET_PC;
      foreach (m_v[k]) m_v[k] = 1'b0;
      started = 1;
    end else begin
      if (ex_valid && ex_kind != 2'b00) begin
        j    = int'((ex_pc >> 2) % ENTRIES);
        ehit = m_v[j] === 1'b1 && m_tag[j] == (ex_pc >> (IDXW + 2));
        tk   = (ex_kind != 2'b01) || ex_taken;
        if (tk && ehit) begin
          m_tgt[j] = a;
          if (m_cnt[j] < 3) m_cnt[j]++;
        end else if (tk) begin
          m_v[j] = 1'b1; m_tag[j] = ex_pc >> (IDXW + 2); m_tgt[j] = a; m_cnt[j] = 2;
        end else if (ehit && m_cnt[j] > 0) begin
          m_cnt[j]--;
        end
      end
      m_pc = mp ? a : (stall ? m_pc : ptgt);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic ex(input logic [1:0] k, input logic tk, input logic [31:0] p,
                    input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] rg,
                    input logic ptk, input logic [31:0] ptg);
    ex_valid = 1'b1; ex_kind = k; ex_taken = tk; ex_pc = p; ex_imm = imm;
    ex_jaddr = ja; ex_reg = rg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  task automatic noex();
    ex_valid = 1'b0; ex_kind = 2'b00; ex_taken = 1'b0; ex_pc = '0; ex_imm = '0;
    ex_jaddr = '0; ex_reg = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  // Steer fetch to tgt via a not-taken branch that had been predicted taken.
  task automatic redirect(input logic [31:0] tgt);
    cyc();
    ex(2'b01, 1'b0, tgt - 32'd4, 16'h0, 26'h0, 32'h0, 1'b1, 32'hDEAD_0000);
    cyc();
    noex();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; noex();
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pred_taken", 32'(pred_taken), 32'h0);
    chk("rst_pred_target", pred_target, 32'h4);
    chk("rst_flush", 32'(flush), 32'h0);
    cyc(); @(negedge clk); chk("idle_pc4", pc, 32'h4);
    cyc(); @(negedge clk); chk("idle_pc8", pc, 32'h8);
    cyc(); @(negedge clk); chk("idle_pc12", pc, 32'hC);

    // Taken branch at 0x10 unpredicted -> redirect to 0x24, allocate BTB[4].
    cyc();
    ex(2'b01, 1'b1, 32'h10, 16'h0004, 26'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("br_fetch_pc", pc, 32'h10);
    chk("br_flush", 32'(flush), 32'h1);
    cyc(); noex(); @(negedge clk);
    chk("br_redirect_pc", pc, 32'h24);

    // Refetch 0x10 predicts taken; same-cycle not-taken resolve sees old entry.
    redirect(32'h10);
    ex(2'b01, 1'b0, 32'h10, 16'h0004, 26'h0, 32'h0, 1'b1, 32'h24);
    @(negedge clk);
    chk("hit_pred_taken", 32'(pred_taken), 32'h1);
    chk("hit_pred_target", pred_target, 32'h24);
    chk("nt_flush", 32'(flush), 32'h1);
    cyc(); noex(); @(negedge clk);
    chk("nt_redirect_pc", pc, 32'h14);
    redirect(32'h10); @(negedge clk);
    chk("weak_pred_taken", 32'(pred_taken), 32'h0);
    chk("weak_pred_target", pred_target, 32'h14);

    // Redirect overrides stall.
    cyc(); stall = 1'b1;
    ex(2'b10, 1'b0, 32'h4000_0000, 16'h0, 26'h100, 32'h0, 1'b0, 32'h0);
    @(negedge clk); chk("jmp_flush", 32'(flush), 32'h1);
    cyc(); noex(); @(negedge clk);
    chk("jmp_pc", pc, 32'h4000_0400);
    chk("jmp_flush_once", 32'(flush), 32'h0);
    cyc(); @(negedge clk); chk("stall_hold_pc", pc, 32'h4000_0400);
    cyc(); stall = 1'b0;

    // Aliasing at index 0: 0x40 evicts 0x20.
    ex(2'b01, 1'b1, 32'h20, 16'h0008, 26'h0, 32'h0, 1'b0, 32'h0);
    cyc();
    ex(2'b01, 1'b1, 32'h40, 16'h0001, 26'h0, 32'h0, 1'b0, 32'h0);
    cyc(); noex(); @(negedge clk);
    chk("alias_pc", pc, 32'h48);
    redirect(32'h20); @(negedge clk);
    chk("evicted_pred_taken", 32'(pred_taken), 32'h0);
    redirect(32'h40);
    ex(2'b01, 1'b0, 32'h40, 16'h0001, 26'h0, 32'h0, 1'b1, 32'h48);
    @(negedge clk);
    chk("alloc_pred_taken", 32'(pred_taken), 32'h1);
    chk("alloc_pred_target", pred_target, 32'h48);
    cyc();
    ex(2'b01, 1'b0, 32'h40, 16'h0001, 26'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk); chk("correct_nt_flush", 32'(flush), 32'h0);
    cyc();
    ex(2'b01, 1'b1, 32'h40, 16'h0001, 26'h0, 32'h0, 1'b0, 32'h0);
    cyc(); noex();
    redirect(32'h40); @(negedge clk);
    chk("sat0_pred_taken", 32'(pred_taken), 32'h0);

    // Backward branch (negative offset).
    cyc();
    ex(2'b01, 1'b1, 32'h100, 16'hFFFE, 26'h0, 32'h0, 1'b0, 32'h0);
    cyc(); noex(); @(negedge clk);
    chk("neg_off_pc", pc, 32'hFC);

    // Register jump to the top of the address space, then wrap to 0.
    cyc();
    ex(2'b11, 1'b0, 32'h300, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc(); noex(); @(negedge clk);
    chk("reg_pc", pc, 32'hFFFF_FFFC);
    cyc(); @(negedge clk); chk("wrap_pc", pc, 32'h0);
    cyc();
    ex(2'b11, 1'b0, 32'h300, 16'h0, 26'h0, 32'h500, 1'b1, 32'h500);
    @(negedge clk); chk("reg_correct_flush", 32'(flush), 32'h0);
    cyc(); noex();

    // Reset during a redirect wins and empties the BTB.
    ex(2'b11, 1'b0, 32'h200, 16'h0, 26'h0, 32'h80, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk); chk("rst_redirect_flush", 32'(flush), 32'h1);
    cyc(); noex(); rst_n = 1'b1; @(negedge clk);
    chk("rst_mid_pc", pc, RESET_PC);
    chk("rst_mid_pred_taken", 32'(pred_taken), 32'h0);
    redirect(32'h100); @(negedge clk);
    chk("rst_btb_empty", 32'(pred_taken), 32'h0);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
